// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready request -> SETUP/ACCESS transfer -> valid/ready response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states with an error response.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_we_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state_reg;

  // The wait counter is 16 bits wide, so the timeout must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65536");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_reg;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg   <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            PADDR       <= req_addr_i;
            PWRITE      <= req_we_i;
            PWDATA      <= req_wdata_i;
            PSEL        <= 1'b1;
            req_ready_o <= 1'b0;
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE   <= 1'b1;
          state_reg <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        ACCESS: begin
          // PRDATA/PSLVERR are only meaningful on the completing cycle.
          if (PREADY) begin
            rsp_rdata_o <= PWRITE ? 32'd0 : PRDATA;
            rsp_err_o   <= PSLVERR;
            rsp_valid_o <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state_reg   <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt_reg == TIMEOUT_LAST) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state_reg   <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: cycle-exact checks of the APB handshake and response port.
module tb_apb_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic        req_we_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // One full transfer; waits = PREADY-low ACCESS cycles, stall = cycles rsp_ready_i is held low.
  task automatic run_xfer(input logic [11:0] addr, input logic we, input logic [31:0] wdata,
                          input int waits, input logic [31:0] prdata, input logic slverr,
                          input int stall);
    logic [31:0] exp_rdata;
    exp_rdata = we ? 32'd0 : prdata;
    check_eq("idle_req_ready", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_wdata_i = wdata;
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hDEAD_BEEF;
    tick();
    req_valid_i = 1'b0; req_addr_i = ~addr; req_we_i = ~we; req_wdata_i = ~wdata;
    check_eq("setup_psel",    {31'd0, PSEL},        32'd1);
    check_eq("setup_penable", {31'd0, PENABLE},     32'd0);
    check_eq("setup_paddr",   {20'd0, PADDR},       {20'd0, addr});
    check_eq("setup_pwrite",  {31'd0, PWRITE},      {31'd0, we});
    check_eq("setup_pwdata",  PWDATA,               wdata);
    check_eq("setup_ready",   {31'd0, req_ready_o}, 32'd0);
    tick();
    for (int w = 0; w <= waits; w++) begin
      check_eq("access_psel",    {31'd0, PSEL},        32'd1);
      check_eq("access_penable", {31'd0, PENABLE},     32'd1);
      check_eq("access_paddr",   {20'd0, PADDR},       {20'd0, addr});
      check_eq("access_pwdata",  PWDATA,               wdata);
      check_eq("access_rvalid",  {31'd0, rsp_valid_o}, 32'd0);
      if (w == waits) begin
        PREADY = 1'b1; PRDATA = prdata; PSLVERR = slverr;
      end
      tick();
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0BAD_F00D;
    check_eq("resp_valid",   {31'd0, rsp_valid_o}, 32'd1);
    check_eq("resp_rdata",   rsp_rdata_o,          exp_rdata);
    check_eq("resp_err",     {31'd0, rsp_err_o},   {31'd0, slverr});
    check_eq("resp_psel",    {31'd0, PSEL},        32'd0);
    check_eq("resp_penable", {31'd0, PENABLE},     32'd0);
    check_eq("resp_ready",   {31'd0, req_ready_o}, 32'd0);
    $display("xfer addr=0x%03h we=%0d waits=%0d stall=%0d rdata=0x%08h err=%0d",
             addr, we, waits, stall, rsp_rdata_o, rsp_err_o);
    if (stall > 0) begin
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1; req_addr_i = 12'hFFF;
      for (int s = 0; s < stall; s++) begin
        tick();
        check_eq("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
        check_eq("stall_rdata", rsp_rdata_o,          exp_rdata);
        check_eq("stall_err",   {31'd0, rsp_err_o},   {31'd0, slverr});
        check_eq("stall_ready", {31'd0, req_ready_o}, 32'd0);
        check_eq("stall_psel",  {31'd0, PSEL},        32'd0);
      end
      rsp_ready_i = 1'b1;
    end
    tick();
    req_valid_i = 1'b0;
    check_eq("done_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_eq("done_ready", {31'd0, req_ready_o}, 32'd1);
    check_eq("done_psel",  {31'd0, PSEL},        32'd0);
    check_eq("done_paddr", {20'd0, PADDR},       {20'd0, addr});
  endtask

  // Starts a read that is left stuck in ACCESS with PREADY low.
  task automatic start_stuck_read(input logic [11:0] addr);
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = 1'b0; req_wdata_i = 32'd0;
    PREADY = 1'b0; PRDATA = 32'h7777_7777; PSLVERR = 1'b0;
    tick();
    req_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    HRESETn = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_wdata_i = '0;
    rsp_ready_i = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    check_eq("rst_psel",    {31'd0, PSEL},        32'd0);
    check_eq("rst_penable", {31'd0, PENABLE},     32'd0);
    check_eq("rst_pwrite",  {31'd0, PWRITE},      32'd0);
    check_eq("rst_paddr",   {20'd0, PADDR},       32'd0);
    check_eq("rst_pwdata",  PWDATA,               32'd0);
    check_eq("rst_rvalid",  {31'd0, rsp_valid_o}, 32'd0);
    check_eq("rst_rerr",    {31'd0, rsp_err_o},   32'd0);
    check_eq("rst_rdata",   rsp_rdata_o,          32'd0);
    check_eq("rst_ready",   {31'd0, req_ready_o}, 32'd1);
    HRESETn = 1'b1;
    tick();

    run_xfer(12'h004, 1'b1, 32'h0000_1234, 0, 32'h5555_AAAA, 1'b0, 0);
    run_xfer(12'h010, 1'b0, 32'h0000_0000, 3, 32'hCAFE_0001, 1'b0, 0);
    run_xfer(12'h018, 1'b0, 32'h0000_0000, 1, 32'h0000_00A5, 1'b1, 0);
    run_xfer(12'h01C, 1'b0, 32'h0000_0000, 0, 32'h1234_5678, 1'b0, 0);
    run_xfer(12'h100, 1'b0, 32'h0000_0000, 0, 32'h8765_4321, 1'b0, 5);
    run_xfer(12'h008, 1'b1, 32'h0000_A5A5, 0, 32'h0000_0001, 1'b1, 0);
    run_xfer(12'hFFC, 1'b1, 32'hFFFF_FFFF, 15, 32'h0000_0000, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    start_stuck_read(12'h040);
    for (int c = 0; c < 16; c++) begin
      check_eq("to_access_penable", {31'd0, PENABLE},     32'd1);
      check_eq("to_access_rvalid",  {31'd0, rsp_valid_o}, 32'd0);
      tick();
    end
    check_eq("to_rvalid",  {31'd0, rsp_valid_o}, 32'd1);
    check_eq("to_err",     {31'd0, rsp_err_o},   32'd1);
    check_eq("to_rdata",   rsp_rdata_o,          32'd0);
    check_eq("to_psel",    {31'd0, PSEL},        32'd0);
    check_eq("to_penable", {31'd0, PENABLE},     32'd0);
    $display("xfer addr=0x040 we=0 timeout rdata=0x%08h err=%0d", rsp_rdata_o, rsp_err_o);
    tick();
    check_eq("to_done_ready", {31'd0, req_ready_o}, 32'd1);
    start_stuck_read(12'h044);
    tick(); tick();
`else
    start_stuck_read(12'h040);
    repeat (1000) tick();
    $display("xfer addr=0x040 we=0 stuck 1000 cycles psel=%0d penable=%0d", PSEL, PENABLE);
`endif
    check_eq("stuck_psel",    {31'd0, PSEL},        32'd1);
    check_eq("stuck_penable", {31'd0, PENABLE},     32'd1);
    check_eq("stuck_rvalid",  {31'd0, rsp_valid_o}, 32'd0);

    #3 HRESETn = 1'b0;
    #1;
    check_eq("arst_psel",    {31'd0, PSEL},        32'd0);
    check_eq("arst_penable", {31'd0, PENABLE},     32'd0);
    check_eq("arst_rvalid",  {31'd0, rsp_valid_o}, 32'd0);
    check_eq("arst_ready",   {31'd0, req_ready_o}, 32'd1);
    $display("async reset asserted mid-ACCESS");
    #2 HRESETn = 1'b1;
    tick();
    run_xfer(12'h0A0, 1'b0, 32'h0000_0000, 0, 32'h0F0F_1234, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
